// File: rtl/mac_pkg.sv
// Shared types and helpers for the iterative digit-serial MAC sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 8;
    localparam int NDIG_DEF = N_DEF / 2;
    localparam int MAXW = 64;

    // Step counter width for an n-bit operand pair
    function automatic int kw_of(input int n);
        int pairs;
        pairs = (n / 2) * (n / 2);
        return (pairs <= 2) ? 1 : $clog2(pairs);
    endfunction

    function automatic logic [MAXW-1:0] sext5(
        input logic [4:0] p,
        input logic       sgn,
        input int         width
    );
        logic [MAXW-1:0] r;
        r = {{(MAXW-5){sgn & p[4]}}, p};
        if (width < MAXW)
            r = r & ((64'd1 << width) - 64'd1);
        return r;
    endfunction

endpackage

// File: rtl/sbb.sv
// 2x2 signed/unsigned digit multiplier; operands sign-extend only when
// their sign flag is set, result wraps to 5 bits.
module sbb (
    input  logic [1:0] md,
    input  logic [1:0] mr,
    input  logic       sx,
    input  logic       sy,
    output logic [4:0] p
);

    logic signed [4:0] x;
    logic signed [4:0] y;

    assign x = {{3{sx & md[1]}}, md};
    assign y = {{3{sy & mr[1]}}, mr};
    assign p = x * y;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Multiply-accumulate sequencer: one 2x2 digit product per cycle,
// weighted partial sums folded into a wrapping accumulator.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy
);

    localparam int NDIG = N / 2;
    localparam int W2 = 2 * N;
    localparam int KW = kw_of(N);
    localparam logic [KW-1:0] KLAST = KW'(NDIG * NDIG - 1);

    state_t state;
    state_t state_next;

    logic [KW-1:0]    k;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             a_sg;
    logic             b_sg;
    logic             clr_q;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    prod_next;
    logic [W2-1:0]    term;
    logic [ACC_W-1:0] acc_add;
    logic [1:0]       md;
    logic [1:0]       mr;
    logic             sx;
    logic             sy;
    logic [4:0]       p;
    logic             last;
    int               i;
    int               j;

    sbb u_sbb (
        .md (md),
        .mr (mr),
        .sx (sx),
        .sy (sy),
        .p  (p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Digit selection and weighting of the current partial product
    always_comb begin
        i = int'(k) / NDIG;
        j = int'(k) % NDIG;
        md = 2'(a_q >> (2 * i));
        mr = 2'(b_q >> (2 * j));
        sx = a_sg & (i == NDIG - 1);
        sy = b_sg & (j == NDIG - 1);
        term = W2'(sext5(p, sx | sy, W2)) << (2 * (i + j));
        prod_next = prod + term;
        if (a_sg | b_sg)
            acc_add = ACC_W'($signed(prod_next));
        else
            acc_add = ACC_W'(prod_next);
    end

    assign last = (k == KLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_sg    <= 1'b0;
            b_sg    <= 1'b0;
            clr_q   <= 1'b0;
            prod    <= '0;
            acc_out <= '0;
        end else if (state == IDLE && in_valid) begin
            k     <= '0;
            a_q   <= a;
            b_q   <= b;
            a_sg  <= a_signed;
            b_sg  <= b_signed;
            clr_q <= acc_clr;
            prod  <= '0;
        end else if (state == RUN) begin
            k    <= k + 1'b1;
            prod <= prod_next;
            if (last)
                acc_out <= (clr_q ? '0 : acc_out) + acc_add;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized and directed bench for mac_seq_ctrl against an arithmetic
// product/accumulate model.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        a_signed;
    logic        b_signed;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] acc_out;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_acc = 32'd0;

    mac_seq_ctrl #(.N(8), .ACC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic longint ref_product(
        input logic [7:0] x, input logic [7:0] y,
        input logic xs, input logic ys
    );
        longint vx;
        longint vy;
        vx = xs ? longint'($signed(x)) : longint'(x);
        vy = ys ? longint'($signed(y)) : longint'(y);
        return vx * vy;
    endfunction

    function automatic void model_update(
        input logic [7:0] x, input logic [7:0] y,
        input logic xs, input logic ys, input logic clr
    );
        logic [31:0] pr;
        pr = 32'(ref_product(x, y, xs, ys));
        model_acc = clr ? pr : model_acc + pr;
    endfunction

    task automatic run_op(
        input logic [7:0] x, input logic [7:0] y,
        input logic xs, input logic ys, input logic clr,
        input string nm
    );
        int n;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready: in_ready=%b want 1", nm, in_ready);
        end
        a = x; b = y; a_signed = xs; b_signed = ys; acc_clr = clr;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL %s latency: got %0d want 16", nm, n);
        end
        model_update(x, y, xs, ys, clr);
        checks++;
        if (acc_out !== model_acc) begin
            failures++;
            $display("FAIL %s acc: got %h want %h", nm, acc_out, model_acc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s release: in_ready=%b out_valid=%b want 1/0",
                     nm, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; acc_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            acc_out !== 32'd0) begin
            failures++;
            $display("FAIL reset: rdy=%b ov=%b busy=%b acc=%h want 1/0/0/0",
                     in_ready, out_valid, busy, acc_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: rdy=%b busy=%b want 1/0",
                     in_ready, busy);
        end
    endtask

    task automatic test_directed();
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, "uu_max");
        checks++;
        if (acc_out !== 32'h0000FE01) begin
            failures++;
            $display("FAIL uu_max_const: got %h want 0000fe01", acc_out);
        end
        run_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, "ss_min");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, "su_neg");
        checks++;
        if (acc_out !== 32'hFFFFFF01) begin
            failures++;
            $display("FAIL su_neg_const: got %h want ffffff01", acc_out);
        end
        run_op(8'd3, 8'd5, 1'b0, 1'b0, 1'b1, "acc_first");
        run_op(8'hFE, 8'd7, 1'b1, 1'b1, 1'b0, "acc_second");
        run_op(8'h7F, 8'h80, 1'b0, 1'b1, 1'b0, "us_mixed");
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] snap;
        a = 8'h12; b = 8'h34; a_signed = 1'b0; b_signed = 1'b0;
        acc_clr = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        model_update(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        snap = model_acc;
        checks++;
        if (acc_out !== snap) begin
            failures++;
            $display("FAIL bp_acc: got %h want %h", acc_out, snap);
        end
        for (int c = 0; c < 5; c++) begin
            a = $urandom; b = $urandom; acc_clr = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== snap) begin
                failures++;
                $display("FAIL bp_hold%0d: ov=%b rdy=%b acc=%h want 1/0/%h",
                         c, out_valid, in_ready, acc_out, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rdy=%b busy=%b ov=%b want 1/0/0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        run_op(8'd100, 8'd50, 1'b0, 1'b0, 1'b0, "pre_reset");
        a = 8'hC3; b = 8'h5A; a_signed = 1'b1; b_signed = 1'b0;
        acc_clr = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            acc_out !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b busy=%b ov=%b acc=%h want 1/0/0/0",
                     in_ready, busy, out_valid, acc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_acc = 32'd0;
        @(negedge clk);
        run_op(8'd2, 8'd3, 1'b0, 1'b0, 1'b1, "after_reset");
        checks++;
        if (acc_out !== 32'd6) begin
            failures++;
            $display("FAIL after_reset_const: got %0d want 6", acc_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic [7:0] y;
        logic xs;
        logic ys;
        logic clr;
        for (int t = 0; t < 30; t++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            xs = 1'($urandom);
            ys = 1'($urandom);
            clr = ($urandom_range(0, 3) == 0);
            run_op(x, y, xs, ys, clr, $sformatf("rand%0d", t));
        end
    endtask

    task automatic test_back_to_back();
        int last_c;
        int seen;
        last_c = -1;
        seen = 0;
        a = 8'd3; b = 8'd5; a_signed = 1'b0; b_signed = 1'b0; acc_clr = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                model_acc = model_acc + 32'd15;
                checks++;
                if (acc_out !== model_acc) begin
                    failures++;
                    $display("FAIL b2b_acc%0d: got %h want %h",
                             seen, acc_out, model_acc);
                end
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c !== 18) begin
                        failures++;
                        $display("FAIL b2b_period%0d: got %0d want 18",
                                 seen, c - last_c);
                    end
                end
                last_c = c;
                seen++;
                if (seen == 3) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (seen !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d results want 3", seen);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
